// File: rtl/text_pkg.sv
// Shared text-screen geometry, clear fill character and FSM state type
// for the character VRAM write path.
package text_pkg;

  localparam int          COLS   = 70;
  localparam int          ROWS   = 30;
  localparam int          CELLS  = COLS * ROWS;
  localparam int          ADDR_W = 12;
  localparam logic [7:0]  FILL   = 8'h20;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

endpackage

// File: rtl/vram_clear_seq.sv
// Screen-clear address sequencer: walks 0..N_CELLS-1 once per start,
// one address per cycle, and stops on the last cell without wrapping.
module vram_clear_seq
  import text_pkg::*;
#(
  parameter int N_CELLS = text_pkg::CELLS
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] addr
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_CELLS - 1);

  logic              busy_q, busy_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  // cnt_q is the address being written in the current cycle while busy
  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    if (busy_q) begin
      if (cnt_q == LAST) begin
        busy_d = 1'b0;
      end else begin
        cnt_d = cnt_q + ADDR_W'(1);
      end
    end else if (start) begin
      busy_d = 1'b1;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy = busy_q;
  assign done = busy_q && (cnt_q == LAST);
  assign addr = cnt_q;

endmodule

// File: rtl/vram_write_sched.sv
// Character VRAM write scheduler: round-robin between two requesters,
// with a full-screen clear that owns the registered write port while active.
module vram_write_sched
  import text_pkg::*;
#(
  parameter int         COLS = text_pkg::COLS,
  parameter int         ROWS = text_pkg::ROWS,
  parameter logic [7:0] FILL = text_pkg::FILL
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done,
  input  logic              a_req,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [7:0]        a_data,
  input  logic              b_req,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [7:0]        b_data,
  output logic              a_ack,
  output logic              b_ack,
  output logic              addr_err,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_data
);

  localparam int              N_CELLS = COLS * ROWS;
  localparam logic [ADDR_W:0] LIMIT   = (ADDR_W + 1)'(N_CELLS);

  state_t            state_q, state_d;
  logic              clr_start;
  logic              seq_busy, seq_done;
  logic [ADDR_W-1:0] seq_addr;

  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [7:0]        ram_data_q, ram_data_d;
  logic              a_ack_q, a_ack_d;
  logic              b_ack_q, b_ack_d;
  logic              err_q, err_d;
  logic              rr_q, rr_d;   // 0: favour A, 1: favour B

  logic              elig_a, elig_b, gnt_a, gnt_b, in_range;
  logic [ADDR_W-1:0] sel_addr;
  logic [7:0]        sel_data;

  vram_clear_seq #(
    .N_CELLS (N_CELLS)
  ) u_clear_seq (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (clr_start),
    .busy    (seq_busy),
    .done    (seq_done),
    .addr    (seq_addr)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (clr_req)  state_d = ST_CLEAR;
      ST_CLEAR: if (seq_done) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // A requester in its ack cycle is still showing the request just served
  always_comb begin
    elig_a   = a_req && !a_ack_q;
    elig_b   = b_req && !b_ack_q;
    gnt_a    = elig_a && (!elig_b || !rr_q);
    gnt_b    = elig_b && !gnt_a;
    sel_addr = gnt_b ? b_addr : a_addr;
    sel_data = gnt_b ? b_data : a_data;
    in_range = {1'b0, sel_addr} < LIMIT;

    clr_start  = 1'b0;
    ram_we_d   = 1'b0;
    ram_addr_d = ram_addr_q;
    ram_data_d = ram_data_q;
    a_ack_d    = 1'b0;
    b_ack_d    = 1'b0;
    err_d      = 1'b0;
    rr_d       = rr_q;

    case (state_q)
      ST_IDLE: begin
        if (clr_req) begin
          clr_start  = 1'b1;
          ram_we_d   = 1'b1;
          ram_addr_d = '0;
          ram_data_d = FILL;
        end else if (gnt_a || gnt_b) begin
          a_ack_d = gnt_a;
          b_ack_d = gnt_b;
          rr_d    = gnt_a;
          err_d   = !in_range;
          if (in_range) begin
            ram_we_d   = 1'b1;
            ram_addr_d = sel_addr;
            ram_data_d = sel_data;
          end
        end
      end
      ST_CLEAR: begin
        if (!seq_done) begin
          ram_we_d   = 1'b1;
          ram_addr_d = seq_addr + ADDR_W'(1);
          ram_data_d = FILL;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ram_we_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_data_q <= '0;
      a_ack_q    <= 1'b0;
      b_ack_q    <= 1'b0;
      err_q      <= 1'b0;
      rr_q       <= 1'b0;
    end else begin
      ram_we_q   <= ram_we_d;
      ram_addr_q <= ram_addr_d;
      ram_data_q <= ram_data_d;
      a_ack_q    <= a_ack_d;
      b_ack_q    <= b_ack_d;
      err_q      <= err_d;
      rr_q       <= rr_d;
    end
  end

  assign ram_we   = ram_we_q;
  assign ram_addr = ram_addr_q;
  assign ram_data = ram_data_q;
  assign a_ack    = a_ack_q;
  assign b_ack    = b_ack_q;
  assign addr_err = err_q;
  assign clr_busy = seq_busy;
  assign clr_done = seq_done;

endmodule

// File: tb/tb_vram_write_sched.sv
// Self-checking bench for vram_write_sched: directed handshake/clear/reset
// steps plus a randomized two-requester phase against a rule-level model.
module tb_vram_write_sched;

  localparam int         CELLS = 2100;
  localparam logic [7:0] FILL  = 8'h20;

  logic        clk = 1'b0;
  logic        reset_n, clr_req, a_req, b_req;
  logic [11:0] a_addr, b_addr;
  logic [7:0]  a_data, b_data;
  logic        clr_busy, clr_done, a_ack, b_ack, addr_err, ram_we;
  logic [11:0] ram_addr;
  logic [7:0]  ram_data;

  int n_vec = 0;
  int n_bad = 0;

  // Model state: who was granted last, what each requester saw acked, last write
  bit          m_last_b;
  bit          m_ack_a, m_ack_b;
  logic [11:0] m_addr;
  logic [7:0]  m_data;

  always #5 clk = ~clk;

  vram_write_sched #(
    .COLS (70),
    .ROWS (30),
    .FILL (8'h20)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .clr_done (clr_done),
    .a_req    (a_req),
    .a_addr   (a_addr),
    .a_data   (a_data),
    .b_req    (b_req),
    .b_addr   (b_addr),
    .b_data   (b_data),
    .a_ack    (a_ack),
    .b_ack    (b_ack),
    .addr_err (addr_err),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_data (ram_data)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    a_req   = 1'b0;
    b_req   = 1'b0;
    clr_req = 1'b0;
    tick();
    tick();
    check("reset_state",
          {ram_we, a_ack, b_ack, addr_err, clr_busy, clr_done, ram_addr, ram_data}, '0);
    reset_n  = 1'b1;
    m_last_b = 1'b1;
    m_ack_a  = 1'b0;
    m_ack_b  = 1'b0;
    m_addr   = '0;
    m_data   = '0;
  endtask

  function automatic logic [11:0] rand_addr();
    if ($urandom_range(0, 7) == 0) return 12'($urandom_range(CELLS, 4095));
    return 12'($urandom_range(0, CELLS - 1));
  endfunction

  // One idle-mode cycle: predict from the arbitration rules, advance, compare
  task automatic cycle_arb(input string tag);
    bit          ea, eb, ga, gb, inr, we, err;
    logic [11:0] ad;
    logic [7:0]  dt;
    ea = a_req && !m_ack_a;
    eb = b_req && !m_ack_b;
    if (ea && eb) ga = m_last_b;
    else          ga = ea;
    gb  = (ea || eb) && !ga;
    ad  = ga ? a_addr : b_addr;
    dt  = ga ? a_data : b_data;
    inr = int'(ad) < CELLS;
    we  = (ga || gb) && inr;
    err = (ga || gb) && !inr;
    if (we) begin
      m_addr = ad;
      m_data = dt;
    end
    if (ga || gb) m_last_b = gb;
    tick();
    check(tag, {ram_we, a_ack, b_ack, addr_err, ram_addr, ram_data},
          {we, ga, gb, err, m_addr, m_data});
    m_ack_a = ga;
    m_ack_b = gb;
  endtask

  task automatic req_update(input bit allow);
    if (a_req && a_ack) a_req = 1'b0;
    if (b_req && b_ack) b_req = 1'b0;
    if (allow && !a_req && ($urandom_range(0, 1) == 1)) begin
      a_req  = 1'b1;
      a_addr = rand_addr();
      a_data = 8'($urandom);
    end
    if (allow && !b_req && ($urandom_range(0, 1) == 1)) begin
      b_req  = 1'b1;
      b_addr = rand_addr();
      b_data = 8'($urandom);
    end
  endtask

  initial begin
    reset_n = 1'b0; clr_req = 1'b0;
    a_req = 1'b0; a_addr = '0; a_data = '0;
    b_req = 1'b0; b_addr = '0; b_data = '0;

    // Reset, then first request at the first edge out of reset
    do_reset();
    a_req = 1'b1; a_addr = 12'd5; a_data = 8'h41;
    tick();
    check("first_write", {ram_we, ram_addr, ram_data, a_ack, b_ack},
          {1'b1, 12'd5, 8'h41, 1'b1, 1'b0});
    a_req = 1'b0;
    tick();
    check("ack_pulse_hold", {a_ack, ram_we, ram_addr, ram_data},
          {1'b0, 1'b0, 12'd5, 8'h41});

    // Both requesters held high: strict alternation starting with A
    do_reset();
    a_req = 1'b1; a_addr = 12'd10; a_data = 8'h01;
    b_req = 1'b1; b_addr = 12'd20; b_data = 8'h02;
    for (int k = 0; k < 8; k++) begin
      tick();
      check("alternate", {a_ack, b_ack, ram_we, ram_addr},
            (k % 2 == 0) ? {2'b10, 1'b1, 12'd10} : {2'b01, 1'b1, 12'd20});
    end
    a_req = 1'b0; b_req = 1'b0;

    // Randomized requesters, including out-of-range addresses
    do_reset();
    for (int i = 0; i < 300; i++) begin
      req_update(1'b1);
      cycle_arb("random");
    end
    for (int i = 0; i < 8; i++) begin
      req_update(1'b0);
      cycle_arb("drain");
    end
    req_update(1'b0);

    a_req = 1'b1; a_addr = 12'd2100; a_data = 8'h99;
    cycle_arb("oor");
    check("oor_flags", {a_ack, addr_err, ram_we}, 3'b110);
    a_req = 1'b0;
    cycle_arb("oor_after");

    // In-flight write completes, then full clear with B arriving mid-clear
    a_req = 1'b1; a_addr = 12'd7; a_data = 8'h37;
    cycle_arb("pre_clear_write");
    check("pre_clear_write_port", {ram_we, ram_addr, ram_data}, {1'b1, 12'd7, 8'h37});
    a_req   = 1'b0;
    clr_req = 1'b1;
    for (int i = 0; i < CELLS; i++) begin
      tick();
      clr_req = 1'b0;
      check("clear_seq", {ram_we, ram_addr, ram_data, clr_busy, clr_done, a_ack, b_ack},
            {1'b1, 12'(i), FILL, 1'b1, (i == CELLS - 1), 1'b0, 1'b0});
      if (i == 500) begin
        b_req = 1'b1; b_addr = 12'd100; b_data = 8'h5A;
      end
    end
    tick();
    check("clear_end", {clr_busy, clr_done, ram_we, b_ack, ram_addr}, {4'b0000, 12'd2099});
    tick();
    check("post_clear_b", {b_ack, a_ack, ram_we, ram_addr, ram_data},
          {1'b1, 1'b0, 1'b1, 12'd100, 8'h5A});
    b_req = 1'b0;

    // Clear beats a same-cycle request; reset at address 1000 abandons it
    clr_req = 1'b1;
    a_req = 1'b1; a_addr = 12'd33; a_data = 8'h77;
    for (int i = 0; i <= 1000; i++) begin
      tick();
      clr_req = 1'b0;
      check("clear_partial", {ram_we, ram_addr, clr_busy, clr_done, a_ack},
            {1'b1, 12'(i), 1'b1, 1'b0, 1'b0});
    end
    reset_n = 1'b0;
    tick();
    check("reset_mid_clear", {clr_busy, ram_we, clr_done, a_ack}, 4'b0000);
    reset_n = 1'b1;
    tick();
    check("first_after_reset", {a_ack, b_ack, ram_we, ram_addr, ram_data},
          {1'b1, 1'b0, 1'b1, 12'd33, 8'h77});
    a_req = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("no_resumed_clear", {ram_we, clr_busy, clr_done}, 3'b000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
